cordic_sincos: RTL and testbench

Iterative CORDIC engine in rotation mode. It takes an angle and produces its cosine and sine, making it the inverse-direction companion of the vectoring-mode arctangent unit. It sits in the same fixed-point datapath and uses the same Q2.13 signed format, so an arctan result can be fed straight back in as an angle. It accepts one angle at a time through a ready/valid handshake and returns both results together with a one-cycle valid pulse.

---
 rtl/cordic_sincos.sv | 172 +++++++++++++++++
 tb/tb_cordic_sincos.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/cordic_sincos.sv
// Iterative rotation-mode CORDIC: a Q2.13 angle in radians gives its Q2.13 cosine and sine.
// The angle is folded into [-pi/2, pi/2] at load, and the fold is undone by negating the results.
module cordic_sincos #(
   parameter int unsigned ITERS = 13,
   parameter int unsigned GUARD = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] theta_in,
   input  logic        valid_in,
   output logic        ready_out,
   output logic [15:0] cos_out,
   output logic [15:0] sin_out,
   output logic        valid_out
);
   localparam int unsigned W  = 16 + GUARD + 1;
   localparam int unsigned IW = 4;

   localparam logic signed [W-1:0] PI      = W'(25736);
   localparam logic signed [W-1:0] HALF_PI = W'(12868);
   localparam logic signed [W-1:0] K_INIT  = W'(4975 * (1 << GUARD));
   localparam logic signed [W-1:0] RND     = W'(1 << (GUARD - 1));
   localparam logic signed [W-1:0] SAT_HI  = W'(8192);
   localparam logic signed [W-1:0] SAT_LO  = W'(-8192);

   typedef enum logic {IDLE, ROTATE} state_t;

   state_t                state_q, state_d;
   logic signed [W-1:0]   x_q, x_d, y_q, y_d, z_q, z_d;
   logic [IW-1:0]         i_q, i_d;
   logic                  neg_q, neg_d;
   logic                  ready_q, ready_d;
   logic                  valid_q, valid_d;
   logic [15:0]           cos_q, cos_d, sin_q, sin_d;

   logic signed [W-1:0]   theta_s, z_fold;
   logic                  fold;
   logic signed [W-1:0]   xs, ys, at, x_n, y_n, z_n;

   // atan(2^-i) in Q2.13, widened by the guard bits
   function automatic logic signed [W-1:0] atan_scaled(input logic [IW-1:0] idx);
      int unsigned v;
      case (idx)
         4'd0:    v = 6434;
         4'd1:    v = 3798;
         4'd2:    v = 2007;
         4'd3:    v = 1019;
         4'd4:    v = 511;
         4'd5:    v = 256;
         4'd6:    v = 128;
         4'd7:    v = 64;
         4'd8:    v = 32;
         4'd9:    v = 16;
         4'd10:   v = 8;
         4'd11:   v = 4;
         4'd12:   v = 2;
         default: v = 1;
      endcase
      return W'(v << GUARD);
   endfunction

   // Drop guard bits with round-half-up, undo the quadrant fold, clamp to +/-1.0
   function automatic logic [15:0] finish(input logic signed [W-1:0] v, input logic neg);
      logic signed [W-1:0] r;
      r = (v + RND) >>> GUARD;
      if (neg) r = -r;
      if (r > SAT_HI)      r = SAT_HI;
      else if (r < SAT_LO) r = SAT_LO;
      return 16'(r);
   endfunction

   always_comb begin : quadrant_fold
      theta_s = W'(signed'(theta_in));
      fold    = 1'b0;
      z_fold  = theta_s;
      if (theta_s > HALF_PI) begin
         z_fold = theta_s - PI;
         fold   = 1'b1;
      end else if (theta_s < -HALF_PI) begin
         z_fold = theta_s + PI;
         fold   = 1'b1;
      end
   end

   always_comb begin : micro_rotation
      xs = x_q >>> i_q;
      ys = y_q >>> i_q;
      at = atan_scaled(i_q);
      if (!z_q[W-1]) begin
         x_n = x_q - ys;
         y_n = y_q + xs;
         z_n = z_q - at;
      end else begin
         x_n = x_q + ys;
         y_n = y_q - xs;
         z_n = z_q + at;
      end
   end

   always_comb begin : next_state
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      z_d     = z_q;
      i_d     = i_q;
      neg_d   = neg_q;
      ready_d = ready_q;
      valid_d = 1'b0;
      cos_d   = cos_q;
      sin_d   = sin_q;
      case (state_q)
         IDLE: begin
            ready_d = 1'b1;
            if (ready_q && valid_in) begin
               state_d = ROTATE;
               ready_d = 1'b0;
               x_d     = K_INIT;
               y_d     = '0;
               z_d     = z_fold <<< GUARD;
               neg_d   = fold;
               i_d     = '0;
            end
         end
         ROTATE: begin
            x_d = x_n;
            y_d = y_n;
            z_d = z_n;
            i_d = i_q + IW'(1);
            // ready stays low through the result cycle and rises the cycle after
            if (i_q == IW'(ITERS - 1)) begin
               state_d = IDLE;
               i_d     = '0;
               valid_d = 1'b1;
               cos_d   = finish(x_n, neg_q);
               sin_d   = finish(y_n, neg_q);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
         i_q     <= '0;
         neg_q   <= 1'b0;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
         cos_q   <= '0;
         sin_q   <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         z_q     <= z_d;
         i_q     <= i_d;
         neg_q   <= neg_d;
         ready_q <= ready_d;
         valid_q <= valid_d;
         cos_q   <= cos_d;
         sin_q   <= sin_d;
      end
   end

   assign ready_out = ready_q;
   assign valid_out = valid_q;
   assign cos_out   = cos_q;
   assign sin_out   = sin_q;
endmodule

// File: tb/tb_cordic_sincos.sv
// Bench for cordic_sincos: directed corner angles, random angles and handshake/reset scenarios
// checked against real-valued cos/sin.
module tb_cordic_sincos;
   localparam int unsigned ITERS = 13;
   localparam int          TOL   = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] theta_in;
   logic        valid_in;
   logic        ready_out;
   logic [15:0] cos_out;
   logic [15:0] sin_out;
   logic        valid_out;

   int n_cmp = 0;
   int n_err = 0;

   cordic_sincos #(.ITERS(ITERS), .GUARD(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .theta_in  (theta_in),
      .valid_in  (valid_in),
      .ready_out (ready_out),
      .cos_out   (cos_out),
      .sin_out   (sin_out),
      .valid_out (valid_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp, input int tol = 0);
      n_cmp++;
      if (got > exp + tol || got < exp - tol) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
      end
   endtask

   // Ideal trig of a Q2.13 angle, rounded to Q2.13
   function automatic int ref_trig(input int th, input bit want_sin);
      real a, v;
      a = real'(th) / 8192.0;
      v = want_sin ? $sin(a) : $cos(a);
      return int'($floor(v * 8192.0 + 0.5));
   endfunction

   function automatic int s16(input logic [15:0] v);
      return int'(signed'(v));
   endfunction

   task automatic wait_ready(input string tag);
      int n;
      n = 0;
      while (!ready_out && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!ready_out) check({tag, "_ready_timeout"}, 0, 1);
   endtask

   // One transaction; optionally pokes valid_in with another angle mid-rotation
   task automatic run_one(input int th, input string tag, input bit poke = 1'b0,
                          input int poke_th = 0);
      int got_k, rdy_bad;
      wait_ready(tag);
      theta_in = 16'(th);
      valid_in = 1'b1;
      @(negedge clk);
      valid_in = 1'b0;
      got_k   = -1;
      rdy_bad = ready_out ? 1 : 0;
      for (int k = 1; k <= 20 && got_k < 0; k++) begin
         if (poke && k == 5) begin
            theta_in = 16'(poke_th);
            valid_in = 1'b1;
         end else begin
            valid_in = 1'b0;
         end
         @(negedge clk);
         if (valid_out) got_k = k;
         if (ready_out) rdy_bad++;
      end
      valid_in = 1'b0;
      check({tag, "_latency"}, got_k, ITERS);
      check({tag, "_ready_low"}, rdy_bad, 0);
      check({tag, "_cos"}, s16(cos_out), ref_trig(th, 1'b0), TOL);
      check({tag, "_sin"}, s16(sin_out), ref_trig(th, 1'b1), TOL);
      @(negedge clk);
      check({tag, "_pulse_width"}, int'(valid_out), 0);
      check({tag, "_ready_back"}, int'(ready_out), 1);
      check({tag, "_cos_hold"}, s16(cos_out), ref_trig(th, 1'b0), TOL);
   endtask

   initial begin
      int bad_rdy, bad_vld, bad_out, n_acc, n_res, n_win, th;
      int exp_q[$];

      rst      = 1'b1;
      valid_in = 1'b0;
      theta_in = '0;
      repeat (3) @(negedge clk);
      check("rst_ready", int'(ready_out), 1);
      check("rst_valid", int'(valid_out), 0);
      check("rst_cos", s16(cos_out), 0);
      check("rst_sin", s16(sin_out), 0);
      rst = 1'b0;

      bad_rdy = 0; bad_vld = 0; bad_out = 0;
      repeat (50) begin
         @(negedge clk);
         if (!ready_out) bad_rdy++;
         if (valid_out) bad_vld++;
         if (cos_out != 16'd0 || sin_out != 16'd0) bad_out++;
      end
      check("idle_ready_drops", bad_rdy, 0);
      check("idle_spurious_valid", bad_vld, 0);
      check("idle_outputs_nonzero", bad_out, 0);

      run_one(0, "zero");
      run_one(16'h1921, "pi4");
      run_one(12868, "pi2");
      run_one(16'h4B66, "q2");
      run_one(-16666, "q3");
      run_one(-12868, "mpi2");
      run_one(25736, "pi");
      run_one(-25736, "mpi");
      run_one(16'h1921, "poke", 1'b1, 16'h4B66);

      for (int r = 0; r < 20; r++)
         run_one(int'($urandom_range(51472, 0)) - 25736, $sformatf("rnd%0d", r));

      // valid_in held high with alternating angles; only angles seen with ready_out=1 count
      wait_ready("stress");
      n_acc = 0; n_res = 0;
      for (int c = 0; c < 40; c++) begin
         if (valid_out) begin
            n_res++;
            if (exp_q.size() == 0) check("stress_extra_result", 1, 0);
            else begin
               th = exp_q.pop_front();
               check("stress_cos", s16(cos_out), ref_trig(th, 1'b0), TOL);
               check("stress_sin", s16(sin_out), ref_trig(th, 1'b1), TOL);
            end
         end
         th       = (c % 2 == 0) ? 16'h1921 : 0;
         theta_in = 16'(th);
         valid_in = 1'b1;
         if (ready_out) begin
            exp_q.push_back(th);
            n_acc++;
         end
         @(negedge clk);
      end
      valid_in = 1'b0;
      n_win = n_res;
      for (int c = 0; c < 40; c++) begin
         if (valid_out) begin
            n_res++;
            if (exp_q.size() == 0) check("stress_extra_result", 1, 0);
            else begin
               th = exp_q.pop_front();
               check("stress_cos", s16(cos_out), ref_trig(th, 1'b0), TOL);
               check("stress_sin", s16(sin_out), ref_trig(th, 1'b1), TOL);
            end
         end
         @(negedge clk);
      end
      check("stress_results_in_window", n_win, 2);
      check("stress_results_total", n_res, n_acc);

      // Reset five cycles into a rotation
      wait_ready("abort");
      theta_in = 16'h1921;
      valid_in = 1'b1;
      @(negedge clk);
      valid_in = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort_ready", int'(ready_out), 1);
      check("abort_valid", int'(valid_out), 0);
      check("abort_cos", s16(cos_out), 0);
      check("abort_sin", s16(sin_out), 0);
      @(negedge clk);
      rst = 1'b0;
      bad_vld = 0;
      repeat (20) begin
         @(negedge clk);
         if (valid_out) bad_vld++;
      end
      check("abort_no_result", bad_vld, 0);
      check("abort_cos_held", s16(cos_out), 0);
      run_one(0, "after_abort");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
